ram_rd_arbiter: RTL and testbench
=================================

RAM_RD_ARBITER -- requirements
Module: ram_rd_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 10, RAM word width.
REQ-002 The module SHALL have parameter ADDR_WIDTH, default 12, RAM address width.
REQ-003 The module SHALL have parameter RD_LATENCY, default 1, cycles from RAM read request to valid RAM read data (range 1-4).
REQ-004 Clock and reset SHALL be: clk in 1, single clock, all logic on rising edge; rst in 1, synchronous, active-high reset.
REQ-005 Requester ports SHALL be, for i in {0,1}: req{i}_valid in 1, read request; req{i}_addr in ADDR_WIDTH, read address; req{i}_ready out 1, request accepted this cycle.
REQ-006 Response ports SHALL be, for i in {0,1}: rsp{i}_valid out 1, read data valid; rsp{i}_data out DATA_WIDTH, read data.
REQ-007 Write-snoop ports SHALL be: wr_req in 1, RAM write this cycle; wr_addr in ADDR_WIDTH, RAM write address.
REQ-008 RAM-side ports SHALL be: s_read_req out 1, RAM read strobe; s_read_addr out ADDR_WIDTH, RAM read address; s_read_data in DATA_WIDTH, RAM read data.

Function
REQ-009 At most one request SHALL be granted per cycle; a request transfers when reqN_valid and reqN_ready are both high.
REQ-010 Arbitration SHALL be round-robin: after a grant to requester N, the other requester has priority in the next contested cycle; after reset, requester 0 has priority.
REQ-011 An uncontested valid request SHALL be granted in the same cycle, with zero bubble.
REQ-012 On a grant, s_read_req SHALL be 1 and s_read_addr SHALL equal the granted address in the same cycle, combinationally; otherwise s_read_req SHALL be 0 and s_read_addr SHALL hold its last granted value.
REQ-013 A request SHALL NOT be granted in a cycle where wr_req=1 and wr_addr equals its address (RAW hazard stall); the other requester MAY be granted that cycle, and the round-robin pointer SHALL NOT advance for the stalled requester.
REQ-014 The module SHALL track each grant with a RD_LATENCY-deep pipeline of {valid, id} bits.
REQ-015 Exactly RD_LATENCY cycles after a grant to requester N, rspN_valid SHALL pulse high for one cycle with rspN_data = s_read_data.
REQ-016 Responses SHALL return in grant order and SHALL NOT be back-pressured.
REQ-017 rspN_data SHALL be registered and SHALL hold its value while rspN_valid=0.
REQ-018 A requester SHALL hold reqN_valid and reqN_addr stable until ready; the module is not required to handle a withdrawn request.
REQ-019 Back-to-back grants on every cycle SHALL sustain full throughput (one read per cycle).

Reset
REQ-020 While rst=1: all req ready outputs SHALL be 0; s_read_req=0; s_read_addr=0; rsp0/1_valid=0; rsp0/1_data=0; the tracking pipeline SHALL be cleared; the priority pointer SHALL be set to requester 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight responses; no rspN_valid SHALL occur for grants made before or during reset.
REQ-022 The first grant SHALL be possible in the first cycle after rst deasserts.

Structure
REQ-023 A shared package SHALL hold the requester-id width (1), the requester count (2) and the RD_LATENCY range constants.
REQ-024 The round-robin arbiter SHALL be a sub-module, rr_arb2: 2 requests in, one-hot grant out, pointer update on a grant-advance input.
REQ-025 The RAM itself SHALL remain outside this block.

Verification
REQ-026 Reset: assert rst for 3 cycles with both requests valid -> ready0=ready1=0, no s_read_req, no rsp*_valid.
REQ-027 Contention: both requests valid for 4 cycles, addr0=0x010, addr1=0x020 -> grants 0,1,0,1; rsp0 returns mem[0x010] and rsp1 returns mem[0x020], each RD_LATENCY cycles after its grant.
REQ-028 RAW stall: req0 addr=0x005 with wr_req=1, wr_addr=0x005, wr_data=0x3AB -> no grant that cycle; next-cycle grant returns 0x3AB.
REQ-029 Stall bypass: same as REQ-028 plus req1 addr=0x006 -> req1 granted in the stall cycle, req0 granted next cycle.
REQ-030 Throughput: req1 alone valid for 16 consecutive addresses 0x000-0x00F, RD_LATENCY=2 -> 16 consecutive rsp1_valid pulses with data in address order.
REQ-031 Mid-flight reset: grant to req0, then rst asserted 1 cycle later -> no rsp0_valid pulse ever appears for that grant.

Source files
------------

// File: rtl/ram_rd_arbiter_pkg.sv
// Shared constants and types for the two-port RAM read arbiter.
package ram_rd_arbiter_pkg;

  localparam int ID_W       = 1;  // requester id width
  localparam int N_REQ      = 2;  // number of requesters
  localparam int RD_LAT_MIN = 1;  // smallest supported RAM read latency
  localparam int RD_LAT_MAX = 4;  // largest supported RAM read latency

  typedef logic [ID_W-1:0] req_id_t;

  // One slot of the in-flight read tracker.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } trk_t;

endpackage

// File: rtl/ram_rd_arbiter_if.sv
// Bus bundle for the read arbiter: requesters, responses, write snoop and RAM side.
// slave = arbiter view, master = environment (requesters + RAM) view.
interface ram_rd_arbiter_if
  import ram_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12
);
  logic                  req0_valid;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic                  req0_ready;
  logic                  req1_valid;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic                  req1_ready;

  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;

  logic                  s_read_req;
  logic [ADDR_WIDTH-1:0] s_read_addr;
  logic [DATA_WIDTH-1:0] s_read_data;

  modport slave (
    input  req0_valid, req0_addr, req1_valid, req1_addr,
    input  wr_req, wr_addr, s_read_data,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output s_read_req, s_read_addr
  );

  modport master (
    output req0_valid, req0_addr, req1_valid, req1_addr,
    output wr_req, wr_addr, s_read_data,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  s_read_req, s_read_addr
  );

endinterface

// File: rtl/ram_rd_arbiter_rr_arb2.sv
// Two-input round-robin arbiter: one-hot grant, pointer moves only on i_advance.
module rr_arb2
  import ram_rd_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_advance,
  output logic [N_REQ-1:0] o_grant
);

  logic r_prio;  // requester that wins the next contested cycle

  // Contested cycles go to the priority holder; otherwise grant whoever asks.
  always_comb begin
    o_grant = '0;
    if (&i_req) o_grant[r_prio] = 1'b1;
    else        o_grant = i_req;
  end

  // After a grant to requester N the other one gets priority.
  always_ff @(posedge clk) begin
    if (rst)            r_prio <= 1'b0;
    else if (i_advance) r_prio <= o_grant[0];
  end

endmodule

// File: rtl/ram_rd_arbiter.sv
// Arbitrates two read requesters onto one RAM read port, stalls reads that
// collide with a same-cycle write, and steers returning data back to the
// requester that issued it. s_read_data is sampled on the RD_LATENCY-th rising
// edge after the grant, so the registered response appears RD_LATENCY cycles
// after the grant.
module ram_rd_arbiter
  import ram_rd_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 12,
  parameter int RD_LATENCY = 1
)(
  input logic             clk,
  input logic             rst,
  ram_rd_arbiter_if.slave bus
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int LAT = (RD_LATENCY < RD_LAT_MIN) ? RD_LAT_MIN :
                       (RD_LATENCY > RD_LAT_MAX) ? RD_LAT_MAX : RD_LATENCY;

  logic [N_REQ-1:0]      w_elig;
  logic [N_REQ-1:0]      w_grant;
  logic                  w_any_gnt;
  logic [ADDR_WIDTH-1:0] w_gnt_addr;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  trk_t                  w_trk_in;
  trk_t                  w_cap;
  trk_t                  r_trk [LAT];
  logic [DATA_WIDTH-1:0] r_rsp_data [N_REQ];

  // A request is eligible unless in reset or a same-address write is in flight.
  always_comb begin
    w_elig[0] = bus.req0_valid && !rst && !(bus.wr_req && (bus.wr_addr == bus.req0_addr));
    w_elig[1] = bus.req1_valid && !rst && !(bus.wr_req && (bus.wr_addr == bus.req1_addr));
  end

  // A stalled requester is masked here, so it never moves the pointer.
  rr_arb2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .i_req     (w_elig),
    .i_advance (w_any_gnt),
    .o_grant   (w_grant)
  );

  // Granted address and the tracker entry entering the pipeline.
  always_comb begin
    w_any_gnt      = |w_grant;
    w_gnt_addr     = w_grant[1] ? bus.req1_addr : bus.req0_addr;
    w_trk_in.valid = w_any_gnt;
    w_trk_in.id    = w_grant[1];
  end

  // w_cap is the entry whose RAM data is on s_read_data at the coming edge.
  generate
    if (LAT == 1) begin : g_cap_direct
      assign w_cap = w_trk_in;
    end else begin : g_cap_pipe
      assign w_cap = r_trk[LAT-2];
    end
  endgenerate

  // In-flight tracker: one {valid, id} slot per cycle of read latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) r_trk[k] <= '0;
    end else begin
      r_trk[0] <= w_trk_in;
      for (int k = 1; k < LAT; k++) r_trk[k] <= r_trk[k-1];
    end
  end

  // Capture returning RAM data into the owning requester's response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_data[0] <= '0;
      r_rsp_data[1] <= '0;
    end else if (w_cap.valid) begin
      r_rsp_data[w_cap.id] <= bus.s_read_data;
    end
  end

  // Remember the last granted address so s_read_addr holds between grants.
  always_ff @(posedge clk) begin
    if (rst)            r_last_addr <= '0;
    else if (w_any_gnt) r_last_addr <= w_gnt_addr;
  end

  // Outputs are forced quiet during reset, which also drops any response
  // that would otherwise land in the reset cycle itself.
  always_comb begin
    bus.req0_ready  = w_grant[0];
    bus.req1_ready  = w_grant[1];
    bus.s_read_req  = w_any_gnt;
    bus.s_read_addr = w_any_gnt ? w_gnt_addr : (rst ? '0 : r_last_addr);
    bus.rsp0_valid  = !rst && r_trk[LAT-1].valid && (r_trk[LAT-1].id == 1'b0);
    bus.rsp1_valid  = !rst && r_trk[LAT-1].valid && (r_trk[LAT-1].id == 1'b1);
    bus.rsp0_data   = rst ? '0 : r_rsp_data[0];
    bus.rsp1_data   = rst ? '0 : r_rsp_data[1];
  end

endmodule

// File: tb/tb_ram_rd_arbiter.sv
// Bench for ram_rd_arbiter: directed scenarios, a cycle-level reference model
// of the arbitration/response rules, and literal checks on logged events.
module tb_ram_rd_arbiter;

  localparam int DW  = 10;
  localparam int AW  = 12;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  initial forever #5 clk = ~clk;

  ram_rd_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_rd_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM with one read register: data for a read issued in cycle t is on
  // s_read_data during cycle t+1 and gets sampled at the edge ending t+1.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_q;
  logic          init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int a = 0; a < (1 << AW); a++) mem[a] <= DW'(a ^ 'h155);
    end else if (bus.wr_req) begin
      mem[bus.wr_addr] <= wr_data;
    end
    rd_q <= mem[bus.s_read_addr];
  end
  assign bus.s_read_data = rd_q;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct { int cyc; int id; int data; } ev_t;
  typedef struct { int due; int id; logic [DW-1:0] data; } pend_t;
  ev_t   gnt_log[$];
  ev_t   rsp_log[$];
  pend_t pend[$];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_gnt(input string nm, input int k, input int c, input int id);
    if (k >= gnt_log.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: grant %0d missing, got %0d grants, want at least %0d", nm, k, gnt_log.size(), k + 1);
    end else begin
      chk({nm, "_cyc"}, gnt_log[k].cyc, c);
      chk({nm, "_id"},  gnt_log[k].id,  id);
    end
  endtask

  task automatic chk_rsp(input string nm, input int k, input int c, input int id, input int d);
    if (k >= rsp_log.size()) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: response %0d missing, got %0d responses, want at least %0d", nm, k, rsp_log.size(), k + 1);
    end else begin
      chk({nm, "_cyc"},  rsp_log[k].cyc,  c);
      chk({nm, "_id"},   rsp_log[k].id,   id);
      chk({nm, "_data"}, rsp_log[k].data, d);
    end
  endtask

  // Reference model and per-cycle compare, sampled on the falling edge.
  initial begin : model
    int            last_gnt;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] last_data [2];
    bit            e0, e1, rv0, rv1;
    int            g;
    logic [AW-1:0] ga;
    last_gnt = 1; last_addr = '0; last_data[0] = '0; last_data[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        last_gnt = 1; last_addr = '0; last_data[0] = '0; last_data[1] = '0;
        chk("rst_ready0",      int'(bus.req0_ready),  0);
        chk("rst_ready1",      int'(bus.req1_ready),  0);
        chk("rst_s_read_req",  int'(bus.s_read_req),  0);
        chk("rst_s_read_addr", int'(bus.s_read_addr), 0);
        chk("rst_rsp0_valid",  int'(bus.rsp0_valid),  0);
        chk("rst_rsp1_valid",  int'(bus.rsp1_valid),  0);
        chk("rst_rsp0_data",   int'(bus.rsp0_data),   0);
        chk("rst_rsp1_data",   int'(bus.rsp1_data),   0);
      end else begin
        e0 = bus.req0_valid && !(bus.wr_req && bus.wr_addr == bus.req0_addr);
        e1 = bus.req1_valid && !(bus.wr_req && bus.wr_addr == bus.req1_addr);
        if (e0 && e1) g = (last_gnt == 0) ? 1 : 0;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        else          g = -1;
        ga  = (g == 1) ? bus.req1_addr : bus.req0_addr;
        rv0 = 1'b0; rv1 = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          if (pend[0].id == 0) rv0 = 1'b1; else rv1 = 1'b1;
          last_data[pend[0].id] = pend[0].data;
          void'(pend.pop_front());
        end
        chk("ready0",      int'(bus.req0_ready),  int'(g == 0));
        chk("ready1",      int'(bus.req1_ready),  int'(g == 1));
        chk("s_read_req",  int'(bus.s_read_req),  int'(g >= 0));
        chk("s_read_addr", int'(bus.s_read_addr), (g >= 0) ? int'(ga) : int'(last_addr));
        chk("rsp0_valid",  int'(bus.rsp0_valid),  int'(rv0));
        chk("rsp1_valid",  int'(bus.rsp1_valid),  int'(rv1));
        chk("rsp0_data",   int'(bus.rsp0_data),   int'(last_data[0]));
        chk("rsp1_data",   int'(bus.rsp1_data),   int'(last_data[1]));
        if (g >= 0) begin
          pend.push_back(pend_t'{cyc + LAT, g, mem[ga]});
          last_gnt  = g;
          last_addr = ga;
        end
      end
      if (bus.req0_ready) gnt_log.push_back(ev_t'{cyc, 0, 0});
      if (bus.req1_ready) gnt_log.push_back(ev_t'{cyc, 1, 0});
      if (bus.rsp0_valid) rsp_log.push_back(ev_t'{cyc, 0, int'(bus.rsp0_data)});
      if (bus.rsp1_valid) rsp_log.push_back(ev_t'{cyc, 1, int'(bus.rsp1_data)});
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    rsp_log.delete();
  endtask

  // Directed scenarios with hand-computed outcomes (mem[a] = a ^ 0x155).
  initial begin : stim
    int s;
    int exp_id [4];
    int exp_d  [4];
    exp_id = '{0, 1, 0, 1};
    exp_d  = '{'h145, 'h175, 'h145, 'h175};

    bus.req0_valid = 1'b1; bus.req0_addr = 12'h010;
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h020;
    bus.wr_req = 1'b0; bus.wr_addr = '0; wr_data = '0;
    rst = 1'b1;

    // Reset with both requests pending.
    tick(); init_done = 1'b1;
    repeat (3) tick();
    chk("reset_grants",    gnt_log.size(), 0);
    chk("reset_responses", rsp_log.size(), 0);

    // Contention: 0,1,0,1 with first grant right after reset release.
    clear_logs();
    rst = 1'b0;
    s = cyc;
    repeat (4) tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (LAT + 2) tick();
    chk("cont_ngrants", gnt_log.size(), 4);
    chk("cont_nrsp",    rsp_log.size(), 4);
    for (int k = 0; k < 4; k++) begin
      chk_gnt("cont_gnt", k, s + k, exp_id[k]);
      chk_rsp("cont_rsp", k, s + k + 2, exp_id[k], exp_d[k]);
    end

    // RAW stall on req0, then granted with the freshly written data.
    clear_logs();
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h005;
    bus.wr_req = 1'b1; bus.wr_addr = 12'h005; wr_data = 10'h3AB;
    s = cyc;
    tick();
    bus.wr_req = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    repeat (4) tick();
    chk("raw_ngrants", gnt_log.size(), 1);
    chk("raw_nrsp",    rsp_log.size(), 1);
    chk_gnt("raw_gnt", 0, s + 1, 0);
    chk_rsp("raw_rsp", 0, s + 3, 0, 'h3AB);

    // Stall bypass: req1 goes in the stall cycle, req0 the cycle after.
    clear_logs();
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h005;
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h006;
    bus.wr_req = 1'b1; bus.wr_addr = 12'h005; wr_data = 10'h0CD;
    s = cyc;
    tick();
    bus.wr_req = 1'b0; bus.req1_valid = 1'b0;
    tick();
    bus.req0_valid = 1'b0;
    repeat (4) tick();
    chk("byp_ngrants", gnt_log.size(), 2);
    chk_gnt("byp_gnt0", 0, s,     1);
    chk_gnt("byp_gnt1", 1, s + 1, 0);
    chk_rsp("byp_rsp0", 0, s + 2, 1, 'h153);
    chk_rsp("byp_rsp1", 1, s + 3, 0, 'h0CD);

    // Throughput: 16 back-to-back reads from req1.
    clear_logs();
    s = cyc;
    for (int i = 0; i < 16; i++) begin
      bus.req1_valid = 1'b1; bus.req1_addr = AW'(i);
      tick();
    end
    bus.req1_valid = 1'b0;
    repeat (4) tick();
    chk("thr_ngrants", gnt_log.size(), 16);
    chk("thr_nrsp",    rsp_log.size(), 16);
    chk_rsp("thr_first", 0,  s + 2,  1, 'h155);
    chk_rsp("thr_mid",   7,  s + 9,  1, 'h152);
    chk_rsp("thr_last",  15, s + 17, 1, 'h15A);

    // Mid-flight reset: the grant made just before reset never returns.
    clear_logs();
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h010;
    s = cyc;
    tick();
    bus.req0_valid = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("mid_ngrants", gnt_log.size(), 1);
    chk_gnt("mid_gnt", 0, s, 0);
    chk("mid_nrsp", rsp_log.size(), 0);

    // Priority pointer is back at requester 0 after that reset.
    clear_logs();
    bus.req0_valid = 1'b1; bus.req0_addr = 12'h010;
    bus.req1_valid = 1'b1; bus.req1_addr = 12'h020;
    s = cyc;
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    repeat (4) tick();
    chk_gnt("post_rst_gnt", 0, s, 0);
    chk_rsp("post_rst_rsp", 0, s + 2, 0, 'h145);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
